// File: rtl/sync_fifo_pmode.sv
// rtl/sync_fifo_pmode.sv - synchronous FIFO, any depth, FWFT or registered read, thresholds and sticky errors
module sync_fifo_pmode #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int FWFT      = 1,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             push_acc, pop_acc;

    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AFULL_TH));
    assign almost_empty = (count_q <= CNT_W'(AEMPTY_TH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Flush masks both requests so it also suppresses the memory write.
    assign push_acc = wr_en & ~full & ~flush;
    assign pop_acc  = rd_en & ~empty & ~flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop_acc) begin
                rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            overflow_d  = overflow_q | (wr_en & full);
            underflow_d = underflow_q | (rd_en & empty);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign rd_data     = empty ? '0 : mem_q[rd_ptr_q];
        assign rd_data_vld = ~empty;
    end else begin : g_reg
        logic [DATA_W-1:0] rd_data_q;
        logic              rd_vld_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q <= '0;
                rd_vld_q  <= 1'b0;
            end else begin
                rd_vld_q <= pop_acc;
                if (pop_acc) begin
                    rd_data_q <= mem_q[rd_ptr_q];
                end
            end
        end

        assign rd_data     = rd_data_q;
        assign rd_data_vld = rd_vld_q;
    end

endmodule

// File: tb/tb_sync_fifo_pmode.sv
// tb/tb_sync_fifo_pmode.sv - directed checks on an FWFT depth-5 FIFO and a registered-read depth-8 FIFO
module tb_sync_fifo_pmode;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_flush, a_wr_en, a_rd_en;
    logic [7:0] a_wr_data, a_rd_data;
    logic       a_vld, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [2:0] a_count;

    logic        b_flush, b_wr_en, b_rd_en;
    logic [15:0] b_wr_data, b_rd_data;
    logic        b_vld, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [3:0]  b_count;

    sync_fifo_pmode #(.DATA_W(8), .DEPTH(5), .FWFT(1), .AFULL_TH(4), .AEMPTY_TH(1)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr_en), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_data_vld(a_vld), .full(a_full),
        .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_udf)
    );

    sync_fifo_pmode #(.DATA_W(16), .DEPTH(8), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(2)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr_en), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_data_vld(b_vld), .full(b_full),
        .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_udf)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_op(input logic w, input logic r, input logic [7:0] d);
        a_wr_en = w; a_rd_en = r; a_wr_data = d;
        tick();
        a_wr_en = 1'b0; a_rd_en = 1'b0;
    endtask

    task automatic b_op(input logic w, input logic r, input logic [15:0] d);
        b_wr_en = w; b_rd_en = r; b_wr_data = d;
        tick();
        b_wr_en = 1'b0; b_rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_flush = 0; a_wr_en = 0; a_rd_en = 0; a_wr_data = 0;
        b_flush = 0; b_wr_en = 0; b_rd_en = 0; b_wr_data = 0;
        #3;
        chk("rst_a_empty", a_empty, 1);
        chk("rst_a_full", a_full, 0);
        chk("rst_a_count", a_count, 0);
        chk("rst_a_ae", a_ae, 1);
        chk("rst_a_af", a_af, 0);
        chk("rst_a_rd_data", a_rd_data, 0);
        chk("rst_a_vld", a_vld, 0);
        chk("rst_a_errs", {a_ovf, a_udf}, 0);
        chk("rst_b_rd_data", b_rd_data, 0);
        chk("rst_b_vld", b_vld, 0);
        chk("rst_b_flags", {b_full, b_empty, b_ovf, b_udf}, 4'b0100);
        #9 rst_n = 1'b1;
        tick();

        // Fill, overflow, drain in order
        for (int i = 1; i <= 5; i++) begin
            a_op(1, 0, 8'(i * 8'h11));
            chk("fill_count", a_count, i);
        end
        chk("fill_full", a_full, 1);
        chk("fill_af", a_af, 1);
        chk("fill_head", a_rd_data, 8'h11);
        a_op(1, 0, 8'h66);
        chk("ovf_set", a_ovf, 1);
        chk("ovf_count", a_count, 5);
        for (int i = 1; i <= 5; i++) begin
            chk("drain_data", a_rd_data, 8'(i * 8'h11));
            a_op(0, 1, 8'h00);
        end
        chk("drain_empty", a_empty, 1);
        chk("drain_rd_zero", a_rd_data, 0);
        chk("drain_vld", a_vld, 0);
        chk("drain_no_udf", a_udf, 0);
        a_flush = 1; tick(); a_flush = 0;
        chk("flush_clr_ovf", a_ovf, 0);

        // Pointer wrap
        for (int i = 0; i < 3; i++) a_op(1, 0, 8'(i + 1));
        for (int i = 0; i < 3; i++) a_op(0, 1, 8'h00);
        for (int i = 0; i < 5; i++) a_op(1, 0, 8'(8'hA0 + i));
        chk("wrap_full", a_full, 1);
        for (int i = 0; i < 5; i++) begin
            chk("wrap_data", a_rd_data, 8'(8'hA0 + i));
            a_op(0, 1, 8'h00);
        end
        chk("wrap_empty", a_empty, 1);

        // Simultaneous push+pop at mid, full and empty
        for (int i = 1; i <= 3; i++) a_op(1, 0, 8'(i));
        a_op(1, 1, 8'h04);
        chk("sim_mid_count", a_count, 3);
        chk("sim_mid_head", a_rd_data, 8'h02);
        a_op(1, 0, 8'h05);
        a_op(1, 0, 8'h06);
        chk("sim_full_pre", a_full, 1);
        a_op(1, 1, 8'h07);
        chk("sim_full_count", a_count, 4);
        chk("sim_full_ovf", a_ovf, 1);
        chk("sim_full_head", a_rd_data, 8'h03);

        // Flush overrides concurrent requests
        a_flush = 1; a_wr_en = 1; a_rd_en = 1; a_wr_data = 8'hEE;
        tick();
        a_flush = 0; a_wr_en = 0; a_rd_en = 0;
        chk("flush_count", a_count, 0);
        chk("flush_empty", a_empty, 1);
        chk("flush_ovf", a_ovf, 0);
        chk("flush_rd_zero", a_rd_data, 0);
        a_op(1, 0, 8'h99);
        chk("post_flush_head", a_rd_data, 8'h99);
        chk("post_flush_count", a_count, 1);
        a_op(0, 1, 8'h00);
        a_op(1, 1, 8'h42);
        chk("sim_empty_count", a_count, 1);
        chk("sim_empty_udf", a_udf, 1);
        chk("sim_empty_head", a_rd_data, 8'h42);

        // Registered read: one-cycle latency, one-cycle valid pulse
        b_op(1, 0, 16'hDEAD);
        chk("reg_pre_vld", b_vld, 0);
        b_op(0, 1, 16'h0000);
        chk("reg_data", b_rd_data, 16'hDEAD);
        chk("reg_vld", b_vld, 1);
        chk("reg_count", b_count, 0);
        tick();
        chk("reg_vld_drop", b_vld, 0);
        chk("reg_data_hold", b_rd_data, 16'hDEAD);

        // Thresholds at DEPTH=8, AFULL_TH=6, AEMPTY_TH=2
        b_op(1, 0, 16'h0001);
        b_op(1, 0, 16'h0002);
        chk("th_c2_ae", b_ae, 1);
        b_op(1, 0, 16'h0003);
        chk("th_c3_ae", b_ae, 0);
        b_op(1, 0, 16'h0004);
        b_op(1, 0, 16'h0005);
        chk("th_c5_af", b_af, 0);
        b_op(1, 0, 16'h0006);
        chk("th_c6_af", b_af, 1);
        b_op(0, 1, 16'h0000);
        chk("th_pop_count", b_count, 5);
        chk("th_pop_af", b_af, 0);
        chk("th_pop_data", b_rd_data, 16'h0001);
        chk("th_pop_vld", b_vld, 1);

        // Asynchronous reset mid-burst
        a_wr_en = 1; a_wr_data = 8'h5A;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_a_count", a_count, 0);
        chk("arst_a_empty", a_empty, 1);
        chk("arst_a_udf", a_udf, 0);
        chk("arst_a_rd", a_rd_data, 0);
        chk("arst_b_count", b_count, 0);
        chk("arst_b_rd", b_rd_data, 0);
        a_wr_en = 0;
        #2 rst_n = 1'b1;
        a_op(1, 0, 8'h77);
        chk("post_rst_head", a_rd_data, 8'h77);
        chk("post_rst_count", a_count, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
